// File: rtl/ft_tx_arbiter_if.sv
// Stream-side and FT2232H-side signals of the transmit arbiter, bundled with
// modports for the arbiter (slave) and for whatever drives it (master).
interface ft_tx_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             s0_valid_i;
  logic [WIDTH-1:0] s0_data_i;
  logic             s0_ready_o;
  logic             s1_valid_i;
  logic [WIDTH-1:0] s1_data_i;
  logic             s1_ready_o;
  logic             ft_txe_n_i;
  logic             ft_suspend_n_i;
  logic             ft_wr_n_o;
  logic [WIDTH-1:0] ft_data_o;
  logic [1:0]       grant_o;
  logic             busy_o;

  modport slave (
    input  s0_valid_i, s0_data_i, s1_valid_i, s1_data_i, ft_txe_n_i, ft_suspend_n_i,
    output s0_ready_o, s1_ready_o, ft_wr_n_o, ft_data_o, grant_o, busy_o
  );

  modport master (
    output s0_valid_i, s0_data_i, s1_valid_i, s1_data_i, ft_txe_n_i, ft_suspend_n_i,
    input  s0_ready_o, s1_ready_o, ft_wr_n_o, ft_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/ft_tx_arbiter.sv
// Round-robin, burst-limited two-stream scheduler for the FT2232H sync FIFO write port.
// Define FT_TX_HEADER_EN to prefix every grant with a 0xA0|stream header byte.
module ft_tx_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 64
) (
  input logic            ft_clkout_i,
  input logic            rst_n,
  ft_tx_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no grant; arbitrate between valid streams
  // HDR   | granted; waiting to load the header byte (header build only)
  // DATA  | granted; loading stream bytes into the hold register
`ifdef FT_TX_HEADER_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  localparam logic [WIDTH-1:0] HDR_S0 = WIDTH'(8'hA0);
  localparam logic [WIDTH-1:0] HDR_S1 = WIDTH'(8'hA1);
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  localparam logic [7:0] MAX_B = MAX_BURST[7:0];

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic             wr_n;
  logic [1:0]       grant;
  logic [7:0]       burst_cnt;
  logic             last_grant;

  logic             accept;
  logic             ld_ok;
  logic             gidx;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             fire;
  logic             ld_hdr;
  logic             hold_v_nx;
  logic             last_beat;

  // Suspend gates loading too, so the hold register and FSM stay frozen.
  always_comb begin
    accept    = !wr_n && !bus.ft_txe_n_i && bus.ft_suspend_n_i;
    ld_ok     = (!hold_v || accept) && bus.ft_suspend_n_i;
    gidx      = grant[1];
    sel_valid = gidx ? bus.s1_valid_i : bus.s0_valid_i;
    sel_data  = gidx ? bus.s1_data_i : bus.s0_data_i;
    fire      = (state == DATA) && ld_ok && sel_valid;
`ifdef FT_TX_HEADER_EN
    ld_hdr    = (state == HDR) && ld_ok;
`else
    ld_hdr    = 1'b0;
`endif
    hold_v_nx = (fire || ld_hdr) ? 1'b1 : (accept ? 1'b0 : hold_v);
    last_beat = fire && ((burst_cnt + 8'd1) == MAX_B);
  end

  assign bus.s0_ready_o = grant[0] && (state == DATA) && ld_ok;
  assign bus.s1_ready_o = grant[1] && (state == DATA) && ld_ok;
  assign bus.ft_wr_n_o  = wr_n;
  assign bus.ft_data_o  = hold;
  assign bus.grant_o    = grant;
  assign bus.busy_o     = (state != IDLE) || hold_v;

  always_ff @(posedge ft_clkout_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_v     <= 1'b0;
      wr_n       <= 1'b1;
      grant      <= 2'b00;
      burst_cnt  <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      hold_v <= hold_v_nx;
      wr_n   <= !(hold_v_nx && !bus.ft_txe_n_i && bus.ft_suspend_n_i);
      if (fire) begin
        hold <= sel_data;
      end
`ifdef FT_TX_HEADER_EN
      if (ld_hdr) begin
        hold <= gidx ? HDR_S1 : HDR_S0;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.s0_valid_i || bus.s1_valid_i) begin
            // Stream 1 wins when alone, or when both are valid and stream 0 went last.
            grant     <= (bus.s1_valid_i && (!bus.s0_valid_i || !last_grant)) ? 2'b10 : 2'b01;
            burst_cnt <= 8'd0;
`ifdef FT_TX_HEADER_EN
            state     <= HDR;
`else
            state     <= DATA;
`endif
          end
        end
`ifdef FT_TX_HEADER_EN
        HDR: begin
          if (ld_ok) begin
            state <= DATA;
          end
        end
`endif
        DATA: begin
          if (ld_ok) begin
            if (fire) begin
              burst_cnt <= burst_cnt + 8'd1;
            end
            if (last_beat || !sel_valid) begin
              state      <= IDLE;
              grant      <= 2'b00;
              last_grant <= gidx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter (MAX_BURST=4); expected bytes include headers
// only when FT_TX_HEADER_EN is defined.
module tb_ft_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft_tx_arbiter_if #(.WIDTH(8)) bus();

  ft_tx_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .ft_clkout_i(clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int acc_cyc[$];
  logic txe_edge = 1'b1;
  bit txe_mode = 1'b0;
  int s0_left = 0;
  int s1_left = 0;
  logic [7:0] s0_next = 8'h00;
  logic [7:0] s1_next = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic hdr(input int idx);
`ifdef FT_TX_HEADER_EN
    exp_q.push_back(8'hA0 | 8'(idx));
`else
    if (idx > 1) $display("bad header index %0d", idx);
`endif
  endtask

  task automatic burst(input int idx, input logic [7:0] start, input int n);
    hdr(idx);
    for (int k = 0; k < n; k++) exp_q.push_back(start + 8'(k));
  endtask

  task automatic drive_streams();
    bus.s0_valid_i = (s0_left > 0);
    bus.s0_data_i  = s0_next;
    bus.s1_valid_i = (s1_left > 0);
    bus.s1_data_i  = s1_next;
  endtask

  // One clock: sample handshakes mid-cycle, then update stimulus just after the edge.
  task automatic step();
    logic f0, f1;
    @(negedge clk);
    f0 = bus.s0_valid_i && bus.s0_ready_o;
    f1 = bus.s1_valid_i && bus.s1_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    if (f0) begin s0_next++; s0_left--; end
    if (f1) begin s1_next++; s1_left--; end
    drive_streams();
    if (txe_mode) bus.ft_txe_n_i = ((cyc % 7) < 3);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy_o || s0_left != 0 || s1_left != 0) && n < limit) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= limit), 0);
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  always @(posedge clk) txe_edge <= bus.ft_txe_n_i;

  // Monitor: grant/ready consistency, strobe legality and byte scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_outside_grant",
          (bus.s0_ready_o && !bus.grant_o[0]) || (bus.s1_ready_o && !bus.grant_o[1]), 0);
      if (!bus.ft_wr_n_o) chk("strobe_while_txe_high", txe_edge, 0);
      if (!bus.ft_wr_n_o && !bus.ft_txe_n_i && bus.ft_suspend_n_i) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", bus.ft_data_o, 32'hFFFF_FFFF);
        end else begin
          chk("byte", bus.ft_data_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] held;
    int k;
    bus.ft_txe_n_i     = 1'b0;
    bus.ft_suspend_n_i = 1'b1;
    drive_streams();
    step();
    step();
    chk("rst_wr_n", bus.ft_wr_n_o, 1);
    chk("rst_data", bus.ft_data_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", {bus.s0_ready_o, bus.s1_ready_o}, 0);
    rst_n = 1'b1;

    // Single stream, two full bursts back to back.
    acc_cyc.delete();
    burst(0, 8'h10, 4); burst(0, 8'h14, 4);
    s0_next = 8'h10; s0_left = 8; drive_streams();
    wait_drain("single", 200);

    // Both streams valid: stream 0 went last, so stream 1 leads.
    burst(1, 8'h80, 4); burst(0, 8'h00, 4); burst(1, 8'h84, 4); burst(0, 8'h04, 4);
    s0_next = 8'h00; s0_left = 8; s1_next = 8'h80; s1_left = 8; drive_streams();
    wait_drain("round_robin", 300);

    // TXE# high 3 of every 7 cycles.
    for (int b = 0; b < 5; b++) burst(0, 8'h30 + 8'(4 * b), 4);
    s0_next = 8'h30; s0_left = 20; drive_streams();
    txe_mode = 1'b1;
    wait_drain("txe_toggle", 600);
    txe_mode = 1'b0;
    bus.ft_txe_n_i = 1'b0;
    step();

    // Suspend for 10 cycles in the middle of a burst.
    burst(0, 8'h50, 4); burst(0, 8'h54, 4);
    s0_next = 8'h50; s0_left = 8; drive_streams();
    step(); step(); step(); step();
    held = bus.ft_data_o;
    bus.ft_suspend_n_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("suspend_wr_n", bus.ft_wr_n_o, 1);
      chk("suspend_hold", bus.ft_data_o, held);
    end
    bus.ft_suspend_n_i = 1'b1;
    wait_drain("suspend", 300);

    // Stream 1 runs dry after 2 bytes while stream 0 waits.
    acc_cyc.delete();
    burst(1, 8'h90, 2); burst(0, 8'h60, 2);
    s0_next = 8'h60; s0_left = 2; s1_next = 8'h90; s1_left = 2; drive_streams();
    wait_drain("dry", 200);
`ifdef FT_TX_HEADER_EN
    k = 2;
`else
    k = 1;
`endif
    if (acc_cyc.size() > k + 1) chk("dry_gap_le3", (acc_cyc[k+1] - acc_cyc[k]) <= 3, 1);
    else chk("dry_accept_count", acc_cyc.size(), k + 2);

    // Reset in the middle of a burst.
    burst(0, 8'h70, 4); burst(0, 8'h74, 4);
    s0_next = 8'h70; s0_left = 8; drive_streams();
    step(); step(); step(); step();
    rst_n = 1'b0;
    s0_left = 0; drive_streams();
    exp_q.delete();
    step();
    rst_n = 1'b1;
    chk("midrst_wr_n", bus.ft_wr_n_o, 1);
    chk("midrst_grant", bus.grant_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    burst(0, 8'hB0, 1); burst(1, 8'hC0, 1);
    s0_next = 8'hB0; s0_left = 1; s1_next = 8'hC0; s1_left = 1; drive_streams();
    step();
    chk("post_rst_first_grant", bus.grant_o, 2'b01);
    wait_drain("post_rst", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ft_tx_arbiter.md
# ft_tx_arbiter

Two-requester transmit scheduler for the FT2232H synchronous FIFO write port, in the `ft_clkout_i` (60 MHz) domain. It grants the USB byte path to one of two byte streams at a time: stream 0 carries bulk ADC/sample data and stream 1 carries status/control. Grants are round-robin with a per-grant burst limit. The block holds every byte until the FT2232H has actually accepted it, so a byte presented while TXE# rises is re-presented rather than lost. The top level gates `ft_data_o` onto `ft_data_io` with the tristate.

## Interface
- `WIDTH`, 8: byte width of the streams and of the USB data bus.
- `MAX_BURST`, 64: maximum number of data bytes loaded from one stream per grant. Legal range is 1..255.
- `ft_clkout_i`  in  1  FT2232H 60 MHz clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s0_valid_i`  in  1  stream 0 has a byte.
- `s0_data_i`  in  WIDTH  stream 0 byte.
- `s0_ready_o`  out  1  stream 0 byte is consumed at this edge when `s0_valid_i` is also high.
- `s1_valid_i`, `s1_data_i`, `s1_ready_o`: same as stream 0, for stream 1.
- `ft_txe_n_i`  in  1  low when the FT2232H transmit FIFO has room.
- `ft_suspend_n_i`  in  1  low while USB is suspended.
- `ft_wr_n_o`  out  1  write strobe, registered, active-low.
- `ft_data_o`  out  WIDTH  byte presented to the FT2232H, registered.
- `grant_o`  out  2  one-hot current grant; 00 means no grant.
- `busy_o`  out  1  high when the FSM is not in IDLE or the hold register is full.

## Operation
- **Hold register.** One-entry register `hold`/`hold_v` drives `ft_data_o`.
  - Accept condition at an edge: `ft_wr_n_o==0 && ft_txe_n_i==0 && ft_suspend_n_i==1`. When it holds, the FT2232H has taken `ft_data_o`.
  - `load_ok = !hold_v || accept`. The hold register can take a new byte on any cycle where `load_ok` is true.
- **Write strobe.** `ft_wr_n_o` next = `!(hold_v_next && !ft_txe_n_i && ft_suspend_n_i)`.
  - A byte not accepted stays in `hold` unchanged and is re-presented. No byte is ever dropped or duplicated.
- **FSM states:** IDLE, HDR, DATA.
- **IDLE.** Arbitrate; `grant_o` = 00.
  - If both streams are valid, grant the stream not granted last.
  - Otherwise grant whichever stream is valid.
  - After a grant, go to HDR if the header feature is compiled in, else DATA. Reset `burst_cnt` to 0.
- **HDR.** When `load_ok`, load the header byte and go to DATA.
- **DATA.**
  - `sN_ready_o = grant_o[N] && state==DATA && load_ok`. This path is combinational from `ft_txe_n_i`, `ft_suspend_n_i` and state.
  - On a valid&&ready edge: load `sN_data_i` into `hold` and increment `burst_cnt`.
  - Go to IDLE when the byte loaded makes `burst_cnt==MAX_BURST`.
  - Also go to IDLE when `load_ok` is true but the granted `sN_valid_i` is low (stream ran dry).
  - Record `last_grant` on exit.
- **Ungranted stream.** Its ready output is always 0.
- **Suspend.** While `ft_suspend_n_i` is low, there are no accepts and `ft_wr_n_o` is 1. `hold` and the FSM freeze in place, except that IDLE may still grant.
- **Reset.**
  - On reset: `ft_wr_n_o`=1, `ft_data_o`=0, `hold_v`=0, `grant_o`=00, `busy_o`=0, both ready outputs 0, `burst_cnt`=0, `last_grant`=1 (stream 0 wins first).
  - Reset mid-burst discards the held byte; no partial recovery.

## Timing
- **Latency.** A byte consumed at edge N is driven with `ft_wr_n_o=0` from N+1, provided TXE# was low at N. It is written to the FT2232H at edge N+1 if TXE# is still low there.
- **Throughput.** One byte per cycle within a burst.
- **Re-arbitration cost.** One bubble cycle (the IDLE cycle) between grants, plus the header cycle when the header is enabled. The held byte keeps draining during IDLE.
- **TXE# rises at edge N.** No accept at N. `ft_wr_n_o` goes to 1 after N, the byte is held, and it is re-presented with `ft_wr_n_o=0` one cycle after TXE# returns low.
- **Burst limit and dry stream on the same edge.** The limit takes precedence; the only effect is the transition to IDLE.

## Configuration
- `FT_TX_HEADER_EN` defined: each grant emits one header byte ahead of its data. The header is `8'hA0 | N`, where N is the stream index, giving 0xA0 or 0xA1. The host uses it to demultiplex streams.
- Not defined: the HDR state is compiled out, IDLE goes straight to DATA, and the byte stream is raw and interleaved.

## Test plan
- **Single stream, header on, TXE# held low, MAX_BURST=4.** Stream 0 supplies 0x10..0x17. Required FT-side byte sequence: A0,10,11,12,13,A0,14,15,16,17. There is no gap within a burst.
- **Both streams continuously valid, header off, MAX_BURST=2.** Stream 0 counts from 0x00, stream 1 from 0x80. Required FT-side sequence: 00,01,80,81,02,03,82,83.
- **TXE# toggling.** Stream 0 sends an incrementing counter; TXE# is high for 3 cycles every 7 cycles. The accepted bytes must form a contiguous count with no skip and no repeat, and no write strobe may occur while TXE# was high at the edge.
- **Suspend for 10 cycles mid-burst.** `ft_wr_n_o` is held 1, the held byte is unchanged, and the stream resumes with that same byte first.
- **Dry stream.** Stream 1 deasserts valid after 2 bytes with MAX_BURST=64. The FSM returns to IDLE, and if stream 0 is waiting its header or data follows within 2 cycles.
- **Reset mid-burst.** Assert `rst_n`=0 for 1 cycle. On the next cycle `ft_wr_n_o`=1, `grant_o`=00, `busy_o`=0, and stream 0 wins the first grant afterwards.
